mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 31, max cycles in WAIT without mem_done (legal range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 i_req  in  1  instruction-side read request, held until i_done.
REQ-005 i_addr  in  16  instruction fetch address.
REQ-006 i_data  out  16  last instruction-side read data.
REQ-007 i_done  out  1  one-cycle completion pulse, instruction side.
REQ-008 i_stall  out  1  i_req & ~i_done (combinational).
REQ-009 d_rd / d_wr  in  1 each  data-side read / write request, held until d_done.
REQ-010 d_addr, d_wdata  in  16 each  data address / write data.
REQ-011 d_rdata  out  16  last data-side read data; writes leave it unchanged.
REQ-012 d_done  out  1  one-cycle completion pulse, data side.
REQ-013 d_stall  out  1  (d_rd | d_wr) & ~d_done (combinational).
REQ-014 mem_rd / mem_wr  out  1 each  one-cycle command pulses to the shared memory.
REQ-015 mem_addr, mem_wdata  out  16 each  registered command address / write data.
REQ-016 mem_rdata  in  16; mem_done  in  1  memory read data, valid with mem_done.
REQ-017 err  out  1  sticky error flag.
REQ-018 i_grant_cnt, d_grant_cnt  out  16 each  saturating grant counters.

Function
REQ-019 FSM states IDLE, CMD, WAIT, DONE; requests are sampled only in IDLE.
REQ-020 IDLE: if a request is pending, latch the winner, its address and write data, and go to CMD next cycle.
REQ-021 Arbitration: if only one side is pending, it wins; on a tie, D wins unless last_grant==D, in which case I wins.
REQ-022 last_grant updates on every grant.
REQ-023 CMD (exactly one cycle): drive mem_rd (I, or D read) or mem_wr (D write) high, then go to WAIT.
REQ-024 mem_done is accepted only in WAIT; mem_done in any other state is ignored.
REQ-025 WAIT + mem_done: capture mem_rdata into i_data or d_rdata (reads only), then go to DONE.
REQ-026 DONE (exactly one cycle): assert i_done or d_done for the granted side, then go to IDLE.
REQ-027 Latency: request seen in IDLE at cycle t -> command at t+1 -> mem_done at t+1+L (L>=1) -> done at t+2+L.
REQ-028 Timeout: a WAIT counter starts at 0 on entry; if it reaches TIMEOUT with no mem_done, go to DONE, load 0x0000 into the granted side's read data (reads only) and set err.
REQ-029 Illegal request: d_rd & d_wr both high in IDLE sets err, and D is not eligible that cycle; I may still be granted.
REQ-030 Grant counters increment by 1 on each grant of their side and saturate at 0xFFFF.
REQ-031 mem_addr / mem_wdata hold the latched values from CMD until the next grant.

Reset
REQ-032 rst in any state -> IDLE next cycle; any in-flight transaction is dropped with no done pulse.
REQ-033 Reset values: all outputs 0, counters 0, err 0, last_grant=I (so D wins the first tie), WAIT counter 0.

Structure
REQ-034 Package mem_arb_pkg holds the state enum, the grant enum (GNT_I, GNT_D) and the default TIMEOUT constant.
REQ-035 One sub-module, sat_counter (16-bit saturating increment, sync reset), is instantiated twice, once per grant counter.

Verification
REQ-036 Basic I read: after rst, i_req with i_addr=0x0010; mem_rd pulses at t+1 with mem_addr 0x0010; mem_done 4 cycles later with mem_rdata=0xBEEF -> i_done the next cycle, i_data=0xBEEF, i_grant_cnt=1.
REQ-037 Tie after reset: i_req (i_addr=0x0100) and d_rd (d_addr=0x0200) raised together -> D served first, then I; d_grant_cnt=1, i_grant_cnt=1.
REQ-038 Fairness: both sides held for 4 transactions -> grant order D, I, D, I.
REQ-039 Write: d_wr with d_addr=0x0040, d_wdata=0x1234 -> single-cycle mem_wr with those values; d_done after mem_done; d_rdata unchanged.
REQ-040 Timeout and illegal request: mem_done never asserted with TIMEOUT=31 -> done 31 cycles after WAIT entry, read data 0x0000, err=1 until rst; d_rd & d_wr together -> err=1 and no D grant.
REQ-041 Reset mid-op: rst asserted in WAIT, then mem_done arrives 2 cycles later -> no done pulse, FSM in IDLE, counters 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam int TIMEOUT_DEFAULT = 31;

endpackage

// File: rtl/sat_counter.sv
// 16-bit counter that sticks at 0xFFFF instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access,
// alternating grants on contention and bounding each access with a timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        err,
    output logic [15:0] i_grant_cnt,
    output logic [15:0] d_grant_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    grant_e      gnt_q, gnt_d;
    grant_e      last_q, last_d;
    logic        isWr_q, isWr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] iData_q, iData_d;
    logic [15:0] dData_q, dData_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        err_q, err_d;
    logic        iGrant, dGrant;
    logic        dIllegal, dElig;

    assign dIllegal = d_rd & d_wr;
    assign dElig    = d_rd ^ d_wr;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        isWr_d    = isWr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        iData_d   = iData_q;
        dData_d   = dData_q;
        waitCnt_d = waitCnt_q;
        err_d     = err_q;
        iGrant    = 1'b0;
        dGrant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (dIllegal) begin
                    err_d = 1'b1;
                end
                // On contention the side that did not win last time goes first.
                if (i_req && dElig) begin
                    dGrant = (last_q != GNT_D);
                    iGrant = (last_q == GNT_D);
                end else begin
                    dGrant = dElig;
                    iGrant = i_req;
                end
                if (dGrant) begin
                    gnt_d   = GNT_D;
                    last_d  = GNT_D;
                    isWr_d  = d_wr;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = CMD;
                end else if (iGrant) begin
                    gnt_d   = GNT_I;
                    last_d  = GNT_I;
                    isWr_d  = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                waitCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    if (!isWr_q && gnt_q == GNT_I) iData_d = mem_rdata;
                    if (!isWr_q && gnt_q == GNT_D) dData_d = mem_rdata;
                    state_d = DONE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    if (!isWr_q && gnt_q == GNT_I) iData_d = '0;
                    if (!isWr_q && gnt_q == GNT_D) dData_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            last_q    <= GNT_I;
            isWr_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            iData_q   <= '0;
            dData_q   <= '0;
            waitCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            isWr_q    <= isWr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            iData_q   <= iData_d;
            dData_q   <= dData_d;
            waitCnt_q <= waitCnt_d;
            err_q     <= err_d;
        end
    end

    sat_counter u_iGrantCnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (iGrant),
        .count_o (i_grant_cnt)
    );

    sat_counter u_dGrantCnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (dGrant),
        .count_o (d_grant_cnt)
    );

    assign mem_rd    = (state_q == CMD) & ~isWr_q;
    assign mem_wr    = (state_q == CMD) & isWr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = (state_q == DONE) & (gnt_q == GNT_I);
    assign d_done    = (state_q == DONE) & (gnt_q == GNT_D);
    assign i_stall   = i_req & ~i_done;
    assign d_stall   = (d_rd | d_wr) & ~d_done;
    assign i_data    = iData_q;
    assign d_rdata   = dData_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level
// model of who gets granted, when done arrives and what data/flags result.
module tb_mem_arbiter;

    localparam int TO = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_done;
    logic        i_stall;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;
    logic [15:0] i_grant_cnt;
    logic [15:0] d_grant_cnt;

    int checks = 0;
    int fails  = 0;

    // Reference model state: a handful of facts about the transaction history.
    bit          lastWasD;
    int          expICnt;
    int          expDCnt;
    bit          expErr;
    logic [15:0] expIData;
    logic [15:0] expDData;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_done      (i_done),
        .i_stall     (i_stall),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .d_stall     (d_stall),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .err         (err),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        lastWasD = 1'b0;
        expICnt  = 0;
        expDCnt  = 0;
        expErr   = 1'b0;
        expIData = '0;
        expDData = '0;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        i_req     = 1'b0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    // Runs one arbitration round starting in an IDLE cycle with inputs already driven.
    task automatic applyStimulus(input int lat, input logic [15:0] rdata, input bit timeout, input string tag);
        bit          dIll, dOk, gI, gD, wr;
        logic [15:0] expAddr, expWdata, result;
        dIll = d_rd && d_wr;
        dOk  = (d_rd || d_wr) && !dIll;
        if (dIll) expErr = 1'b1;
        if (dOk && i_req) begin
            gD = !lastWasD;
            gI = lastWasD;
        end else begin
            gD = dOk;
            gI = i_req;
        end
        wr       = gD && d_wr;
        expAddr  = gD ? d_addr : i_addr;
        expWdata = d_wdata;

        // mem_done outside WAIT must be ignored.
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        tick();
        if (!gI && !gD) begin
            mem_done = 1'b0;
            checkBit({tag, ".noCmdRd"}, mem_rd, 1'b0);
            checkBit({tag, ".noCmdWr"}, mem_wr, 1'b0);
            checkBit({tag, ".noGrantErr"}, err, expErr);
            checkOutput({tag, ".noGrantDCnt"}, d_grant_cnt, 16'(expDCnt));
            return;
        end
        lastWasD = gD;
        if (gI) expICnt++;
        if (gD) expDCnt++;

        checkBit({tag, ".cmdRd"}, mem_rd, !wr);
        checkBit({tag, ".cmdWr"}, mem_wr, wr);
        checkOutput({tag, ".cmdAddr"}, mem_addr, expAddr);
        if (wr) checkOutput({tag, ".cmdWdata"}, mem_wdata, expWdata);
        checkOutput({tag, ".iCnt"}, i_grant_cnt, 16'(expICnt));
        checkOutput({tag, ".dCnt"}, d_grant_cnt, 16'(expDCnt));

        mem_done = 1'($urandom_range(0, 1));
        tick();
        mem_done = 1'b0;
        checkBit({tag, ".pulseRd"}, mem_rd | mem_wr, 1'b0);
        checkOutput({tag, ".holdAddr"}, mem_addr, expAddr);

        if (timeout) begin
            repeat (TO - 1) tick();
            checkBit({tag, ".earlyDone"}, i_done | d_done, 1'b0);
            tick();
            result = 16'h0000;
            expErr = 1'b1;
        end else begin
            repeat (lat - 1) tick();
            checkBit({tag, ".noDoneYet"}, i_done | d_done, 1'b0);
            mem_done  = 1'b1;
            mem_rdata = rdata;
            tick();
            mem_done  = 1'b0;
            mem_rdata = 16'($urandom);
            result    = rdata;
        end
        if (gI) expIData = result;
        if (gD && !wr) expDData = result;

        checkBit({tag, ".iDone"}, i_done, gI);
        checkBit({tag, ".dDone"}, d_done, gD);
        checkBit({tag, ".iStall"}, i_stall, i_req && !gI);
        checkBit({tag, ".dStall"}, d_stall, (d_rd || d_wr) && !gD);
        checkOutput({tag, ".iData"}, i_data, expIData);
        checkOutput({tag, ".dRdata"}, d_rdata, expDData);
        checkBit({tag, ".err"}, err, expErr);
        tick();
        checkBit({tag, ".doneOneCycle"}, i_done | d_done, 1'b0);
    endtask

    initial begin
        doReset();
        checkOutput("rst.iData", i_data, 16'h0000);
        checkOutput("rst.dRdata", d_rdata, 16'h0000);
        checkOutput("rst.memAddr", mem_addr, 16'h0000);
        checkOutput("rst.memWdata", mem_wdata, 16'h0000);
        checkOutput("rst.iCnt", i_grant_cnt, 16'h0000);
        checkOutput("rst.dCnt", d_grant_cnt, 16'h0000);
        checkBit("rst.flags", i_done | d_done | i_stall | d_stall | mem_rd | mem_wr, 1'b0);
        checkBit("rst.err", err, 1'b0);

        i_req = 1'b1; i_addr = 16'h0010;
        applyStimulus(4, 16'hBEEF, 1'b0, "basicI");
        i_req = 1'b0;
        checkOutput("basicI.final", i_data, 16'hBEEF);

        doReset();
        i_req = 1'b1; i_addr = 16'h0100;
        d_rd  = 1'b1; d_addr = 16'h0200;
        applyStimulus(2, 16'hAAAA, 1'b0, "tieD");
        d_rd = 1'b0;
        applyStimulus(3, 16'h5555, 1'b0, "tieI");
        i_req = 1'b0;

        i_req = 1'b1; d_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1 + k, 16'h1000 + 16'(k), 1'b0, "fair");
        end
        i_req = 1'b0; d_rd = 1'b0;

        d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        applyStimulus(2, 16'h9999, 1'b0, "write");
        d_wr = 1'b0;

        i_req = 1'b1; i_addr = 16'h0077;
        applyStimulus(0, 16'h0000, 1'b1, "timeoutI");
        i_req = 1'b0;
        d_rd = 1'b1; d_addr = 16'h0033;
        applyStimulus(0, 16'h0000, 1'b1, "timeoutD");
        d_rd = 1'b0;
        i_req = 1'b1;
        applyStimulus(2, 16'h4321, 1'b0, "stickyErr");
        i_req = 1'b0;

        doReset();
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0055;
        applyStimulus(1, 16'h0000, 1'b0, "illegalAlone");
        i_req = 1'b1; i_addr = 16'h0066;
        applyStimulus(2, 16'h7777, 1'b0, "illegalWithI");
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;

        doReset();
        i_req = 1'b1; i_addr = 16'h0123;
        tick();
        tick();
        rst = 1'b1; i_req = 1'b0;
        tick();
        rst = 1'b0;
        modelReset();
        tick();
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkBit("midRst.noDone", i_done | d_done | mem_rd | mem_wr, 1'b0);
            tick();
        end
        checkOutput("midRst.iCnt", i_grant_cnt, 16'h0000);
        checkOutput("midRst.iData", i_data, 16'h0000);
        checkBit("midRst.err", err, 1'b0);
        d_rd = 1'b1; d_addr = 16'h0abc;
        applyStimulus(2, 16'hCAFE, 1'b0, "afterRst");
        d_rd = 1'b0;

        for (int n = 0; n < 60; n++) begin
            int sel;
            sel     = int'($urandom_range(0, 9));
            i_req   = 1'($urandom_range(0, 1));
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            d_rd    = (sel >= 2 && sel <= 5) || sel == 9;
            d_wr    = (sel >= 6);
            applyStimulus(int'($urandom_range(1, 6)), 16'($urandom), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
